bcd_conversion_arbiter: RTL and testbench

Shares one sequential shift-and-add-3 binary-to-BCD converter between two requesters, e.g. the stopwatch running-time counter and the lap/split register. A round-robin arbiter grants one request, the FSM runs the conversion one bit per clock, and the block presents a registered BCD result with a done pulse and the ID of the requester served. The display path consumes it, so both sources use a single small iterative converter instead of a combinational double-dabble array.

---
 rtl/bcd_conversion_arbiter_if.sv | 40 ++++
 rtl/bcd_conversion_arbiter.sv | 138 +++++++++++++
 tb/tb_bcd_conversion_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bcd_conversion_arbiter_if.sv
// ---------------------------------------------------------------------------
// bcd_conversion_arbiter_if
// Request/grant and result bundle between two binary sources, the shared
// binary-to-BCD converter and the display path.
//   req_0/req_1       level requests, held until the matching grant
//   value_0/value_1   unsigned binary values, stable while requested
//   grant_0/grant_1   one-cycle grant pulses (value captured that cycle)
//   busy              converter occupied (SHIFT or DONE)
//   done              one-cycle pulse, result outputs newly updated
//   done_id           requester served by the latest conversion
//   bcd_out           packed BCD result, [3:0] is the least significant digit
//   overflow          latest value did not fit in DIGITS digits
// master: requester/display side.  slave: converter side.
// ---------------------------------------------------------------------------
interface bcd_conversion_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
);
    logic                  req_0;
    logic [WIDTH-1:0]      value_0;
    logic                  req_1;
    logic [WIDTH-1:0]      value_1;
    logic                  grant_0;
    logic                  grant_1;
    logic                  busy;
    logic                  done;
    logic                  done_id;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output req_0, value_0, req_1, value_1,
        input  grant_0, grant_1, busy, done, done_id, bcd_out, overflow
    );

    modport slave (
        input  req_0, value_0, req_1, value_1,
        output grant_0, grant_1, busy, done, done_id, bcd_out, overflow
    );
endinterface

// File: rtl/bcd_conversion_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_conversion_arbiter
// One iterative shift-and-add-3 binary-to-BCD converter shared by two
// requesters through a round-robin arbiter. One input bit is shifted per
// clock; the result is registered together with a done pulse and the id of
// the requester that was served.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    bcd_conversion_arbiter_if.slave (requests, grants, result)
// ---------------------------------------------------------------------------
module bcd_conversion_arbiter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    bcd_conversion_arbiter_if.slave  bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last;
    logic               id;
    logic [CNT_W-1:0]   count;
    logic               last_shift;
    logic               pick_0;
    logic               pick_1;

    logic [WIDTH-1:0]   sr;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_nxt;
    logic [WIDTH-1:0]   sr_nxt;
    logic               top_bit;

    logic [ACC_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               id_q;

    function automatic logic [3:0] dabble_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Round-robin choice: on a tie the requester other than `last` wins.
    assign pick_0     = bus.req_0 & (~bus.req_1 | last);
    assign pick_1     = bus.req_1 & (~bus.req_0 | ~last);
    assign last_shift = (count == CNT_W'(WIDTH - 1));

    // Correction, then shift; the bit falling off the top digit is what
    // marks a value too large for DIGITS digits.
    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            acc_adj[4*i +: 4] = dabble_adjust(acc[4*i +: 4]);
        end
        top_bit = acc_adj[ACC_W-1];
        acc_nxt = {acc_adj[ACC_W-2:0], sr[WIDTH-1]};
        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
    end

    // ---- FSM: state register and control/result registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
            id    <= 1'b0;
            count <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            id_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (pick_0 || pick_1)) begin
                last  <= pick_1;
                id    <= pick_1;
                count <= '0;
            end
            if (state == SHIFT) begin
                count <= count + 1'b1;
                // Capture the final shift directly so the result lines up with done.
                if (last_shift) begin
                    bcd_q <= acc_nxt;
                    ovf_q <= ovf | top_bit;
                    id_q  <= id;
                end
            end
        end
    end

    // ---- Datapath registers (no reset: always loaded before use) ----
    always_ff @(posedge clk) begin
        if (state == IDLE && (pick_0 || pick_1)) begin
            sr  <= pick_1 ? bus.value_1 : bus.value_0;
            acc <= '0;
            ovf <= 1'b0;
        end else if (state == SHIFT) begin
            sr  <= sr_nxt;
            acc <= acc_nxt;
            ovf <= ovf | top_bit;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_0 || pick_1) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    // Grants are masked by reset so a held request shows no grant while in reset.
    always_comb begin
        bus.grant_0 = 1'b0;
        bus.grant_1 = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        if (state == IDLE && reset) begin
            bus.grant_0 = pick_0;
            bus.grant_1 = pick_1;
        end
        if (state != IDLE) bus.busy = 1'b1;
        if (state == DONE) bus.done = 1'b1;
    end

    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
    assign bus.done_id  = id_q;
endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_conversion_arbiter
// Directed bench for bcd_conversion_arbiter: single conversions from each
// requester, overflow, round-robin ties, reset during a conversion and a
// short request pulse while busy.
// ---------------------------------------------------------------------------
module tb_bcd_conversion_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    bcd_conversion_arbiter_if #(.WIDTH(32), .DIGITS(8)) bus ();

    bcd_conversion_arbiter #(.WIDTH(32), .DIGITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Request one conversion and follow it to its done pulse.
    task automatic run_conv(input string tag, input bit who, input logic [31:0] val,
                            input logic [31:0] exp_bcd, input bit exp_ovf, input bit pulse_other);
        int lat;
        int busy_n;
        int i;
        if (who) begin
            bus.req_1 = 1'b1; bus.value_1 = val;
        end else begin
            bus.req_0 = 1'b1; bus.value_0 = val;
        end
        #1;
        chk({tag, "_grant"}, who ? bus.grant_1 : bus.grant_0, 1'b1);
        tick();
        if (who) bus.req_1 = 1'b0; else bus.req_0 = 1'b0;
        lat = 0; busy_n = 0; i = 1;
        while (i <= 40 && lat == 0) begin
            if (bus.busy) busy_n++;
            if (bus.done) lat = i;
            else begin
                if (pulse_other && i == 5) bus.req_1 = 1'b1;
                if (pulse_other && i == 6) bus.req_1 = 1'b0;
                tick();
                i++;
            end
        end
        chk({tag, "_latency"}, lat, 33);
        chk({tag, "_busy_cycles"}, busy_n, 33);
        chk({tag, "_bcd"}, bus.bcd_out, exp_bcd);
        chk({tag, "_ovf"}, bus.overflow, exp_ovf);
        chk({tag, "_id"}, bus.done_id, who);
        tick();
        chk({tag, "_done_low"}, bus.done, 1'b0);
        chk({tag, "_busy_low"}, bus.busy, 1'b0);
    endtask

    initial begin
        int w;
        int prev;
        int seen_g1;
        int seen_done;
        checks = 0; errors = 0;
        reset = 1'b0;
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
        bus.value_0 = '0; bus.value_1 = '0;
        tick(); tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_grants", {bus.grant_1, bus.grant_0}, 2'b00);
        chk("rst_bcd", bus.bcd_out, 32'h0);
        chk("rst_ovf", bus.overflow, 1'b0);
        chk("rst_id", bus.done_id, 1'b0);
        reset = 1'b1;
        tick();

        run_conv("zero", 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0);
        run_conv("max8", 1'b1, 32'd99999999, 32'h99999999, 1'b0, 1'b0);
        run_conv("full", 1'b0, 32'hFFFFFFFF, 32'h94967295, 1'b1, 1'b0);
        run_conv("after_ovf", 1'b0, 32'd12345678, 32'h12345678, 1'b0, 1'b0);

        // Fresh reset so the first tie goes to requester 0.
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        bus.value_0 = 32'd12345678;
        bus.value_1 = 32'd87654321;
        bus.req_0 = 1'b1; bus.req_1 = 1'b1;
        #1;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            w = 0;
            while (!(bus.grant_0 || bus.grant_1) && w < 50) begin
                tick(); w++;
            end
            chk("tie_grant_seen", bus.grant_0 | bus.grant_1, 1'b1);
            chk("tie_grant_id", bus.grant_1, n % 2);
            if (n > 0) chk("tie_gap", cyc - prev, 34);
            prev = cyc;
            tick();
            w = 0;
            while (!bus.done && w < 50) begin
                tick(); w++;
            end
            chk("tie_done_id", bus.done_id, n % 2);
            chk("tie_bcd", bus.bcd_out, (n % 2) ? 32'h87654321 : 32'h12345678);
            if (n == 3) begin
                bus.req_0 = 1'b0; bus.req_1 = 1'b0;
            end
        end
        tick();

        // Reset 10 cycles into SHIFT, request kept high.
        bus.req_0 = 1'b1; bus.value_0 = 32'd4321;
        #1;
        chk("rstmid_grant", bus.grant_0, 1'b1);
        for (int k = 0; k < 10; k++) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_done", bus.done, 1'b0);
        chk("rstmid_grants", {bus.grant_1, bus.grant_0}, 2'b00);
        chk("rstmid_bcd", bus.bcd_out, 32'h0);
        chk("rstmid_id", bus.done_id, 1'b0);
        chk("rstmid_ovf", bus.overflow, 1'b0);
        seen_done = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.done) seen_done++;
        end
        chk("rstmid_no_done", seen_done, 0);
        reset = 1'b1;
        run_conv("after_rst", 1'b0, 32'd4321, 32'h00004321, 1'b0, 1'b0);

        // req_1 pulses for one cycle during a conversion and must be dropped.
        run_conv("pulse", 1'b0, 32'd7, 32'h00000007, 1'b0, 1'b1);
        seen_g1 = 0; seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.grant_1) seen_g1++;
            if (bus.done) seen_done++;
        end
        chk("pulse_no_grant1", seen_g1, 0);
        chk("pulse_no_done", seen_done, 0);
        chk("pulse_hold_bcd", bus.bcd_out, 32'h00000007);
        chk("pulse_hold_id", bus.done_id, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
